// File: rtl/pe_frac_pkg.sv
// Shared types and position-code helpers for the 16b_frac PE fraction datapath.
// Used by the priority decoder and by the encoder-side checkers.
package pe_frac_pkg;

  localparam int WIDTH = 20;
  localparam int POS_W = $clog2(WIDTH + 1);

  typedef logic [WIDTH-1:0] frac_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    frac_t onehot;
    frac_t mask;
    pos_t  shamt;
    logic  zero;
    logic  err;
  } side_t;

  // Code k in 1..WIDTH marks bit k-1; code 0 and error codes give no bit.
  function automatic frac_t pos2onehot(input pos_t pos);
    frac_t oh;
    oh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(pos) == i + 1) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  function automatic frac_t pos2mask(input pos_t pos);
    frac_t m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((int'(pos) > i + 1) && (int'(pos) <= WIDTH)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic pos_is_err(input pos_t pos);
    return (int'(pos) > WIDTH);
  endfunction

  function automatic pos_t pos2shamt(input pos_t pos);
    pos_t sh;
    if ((pos == pos_t'(0)) || pos_is_err(pos)) begin
      sh = pos_t'(0);
    end else begin
      sh = pos_t'(WIDTH) - pos;
    end
    return sh;
  endfunction

endpackage

// File: rtl/shl_barrel_20.sv
// Five-level logarithmic left shifter; bits pushed past the MSB are dropped.
module shl_barrel_20
  import pe_frac_pkg::*;
(
  input  frac_t data_i,
  input  pos_t  shamt_i,
  output frac_t data_o
);

  frac_t lvl_s [POS_W+1];

  assign lvl_s[0] = data_i;

  for (genvar g = 0; g < POS_W; g++) begin : g_lvl
    assign lvl_s[g+1] = shamt_i[g] ? (lvl_s[g] << (32'd1 << g)) : lvl_s[g];
  end

  assign data_o = lvl_s[POS_W];

endmodule

// File: rtl/priority_dec_20.sv
// Two-stage valid/ready priority decoder: position code + fraction in, one-hot,
// below-mask, shift amount and normalized fraction out.
module priority_dec_20
  import pe_frac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [WIDTH-1:0] out_mask,
  output logic [POS_W-1:0] out_shamt,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero,
  output logic             out_err
);

  logic  s1_valid_q, s1_valid_d;
  frac_t s1_data_q,  s1_data_d;
  side_t s1_side_q,  s1_side_d;
  logic  s2_valid_q, s2_valid_d;
  frac_t s2_norm_q,  s2_norm_d;
  side_t s2_side_q,  s2_side_d;

  logic  s2_load_s;
  logic  in_ready_s;
  side_t in_side_s;
  frac_t shifted_s;

  // Handshake: S2 frees when empty or drained, S1 moves whenever S2 takes it.
  always_comb begin
    s2_load_s  = !s2_valid_q || out_ready;
    in_ready_s = !s1_valid_q || s2_load_s;
  end

  // Decode the incoming position code into side-band fields.
  always_comb begin
    in_side_s.onehot = pos2onehot(in_pos);
    in_side_s.mask   = pos2mask(in_pos);
    in_side_s.shamt  = pos2shamt(in_pos);
    in_side_s.zero   = (in_pos == pos_t'(0));
    in_side_s.err    = pos_is_err(in_pos);
  end

  shl_barrel_20 u_shl (
    .data_i  (s1_data_q),
    .shamt_i (s1_side_q.shamt),
    .data_o  (shifted_s)
  );

  // Stage 1 next state: capture a beat whenever the stage is free.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_side_d  = s1_side_q;
    if (in_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_side_d = in_side_s;
      end else begin
        s1_data_d = s1_data_q;
        s1_side_d = s1_side_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: error beats carry a cleared fraction.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_norm_d  = s2_norm_q;
    s2_side_d  = s2_side_q;
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_side_d = s1_side_q;
        if (s1_side_q.err) begin
          s2_norm_d = '0;
        end else begin
          s2_norm_d = shifted_s;
        end
      end else begin
        s2_norm_d = s2_norm_q;
        s2_side_d = s2_side_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset empties both stages and clears all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_side_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_norm_q  <= '0;
      s2_side_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_side_q  <= s1_side_d;
      s2_valid_q <= s2_valid_d;
      s2_norm_q  <= s2_norm_d;
      s2_side_q  <= s2_side_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = s2_valid_q;
  assign out_onehot = s2_side_q.onehot;
  assign out_mask   = s2_side_q.mask;
  assign out_shamt  = s2_side_q.shamt;
  assign out_norm   = s2_norm_q;
  assign out_zero   = s2_side_q.zero;
  assign out_err    = s2_side_q.err;

endmodule

// File: tb/tb_priority_dec_20.sv
// Scoreboarded random/directed bench for priority_dec_20.
module tb_priority_dec_20;

  typedef struct {
    logic [19:0] onehot;
    logic [19:0] mask;
    logic [19:0] norm;
    logic [4:0]  shamt;
    logic        zero;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_pos = 5'd0;
  logic [19:0] in_data = 20'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] out_onehot, out_mask, out_norm;
  logic [4:0]  out_shamt;
  logic        out_zero, out_err;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   tp_mode = 1'b0;
  int   or_mode = 0;

  priority_dec_20 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_mask(out_mask), .out_shamt(out_shamt),
    .out_norm(out_norm), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference: leading one at bit pos-1 moves to bit 19; codes above 20 are errors.
  function automatic exp_t model(input int pos, input logic [19:0] data);
    exp_t e;
    logic [39:0] wide;
    e.onehot = 20'd0; e.mask = 20'd0; e.norm = 20'd0; e.shamt = 5'd0;
    e.zero = 1'b0; e.err = 1'b0; e.cyc = 0;
    if (pos > 20) begin
      e.err = 1'b1;
    end else if (pos == 0) begin
      e.zero = 1'b1;
      e.norm = data;
    end else begin
      e.onehot = 20'(40'd1 << (pos - 1));
      e.mask   = e.onehot - 20'd1;
      e.shamt  = 5'(20 - pos);
      wide     = {20'd0, data} << (20 - pos);
      e.norm   = wide[19:0];
    end
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks in_ready, compares outputs against the queue head, pops and pushes.
  initial begin
    exp_t e;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_norm !== 20'd0 ||
            out_onehot !== 20'd0 || out_shamt !== 5'd0 || out_err !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: got valid=%b rdy=%b norm=%h oh=%h sh=%0d err=%b, required 0 1 0 0 0 0",
                   out_valid, in_ready, out_norm, out_onehot, out_shamt, out_err);
        end
        sb_q.delete();
      end else begin
        exp_rdy = !((sb_q.size() == 2) && !out_ready);
        checks++;
        if (in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL in_ready: got %b, required %b (in flight %0d, out_ready %b)",
                   in_ready, exp_rdy, sb_q.size(), out_ready);
        end
        if (out_valid === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out: got out_valid=1 norm=%h, required no beat", out_norm);
          end else begin
            e = sb_q[0];
            if (out_onehot !== e.onehot || out_mask !== e.mask || out_norm !== e.norm ||
                out_shamt !== e.shamt || out_zero !== e.zero || out_err !== e.err) begin
              errors++;
              $display("FAIL out_beat: got oh=%h mask=%h sh=%0d norm=%h z=%b e=%b, required oh=%h mask=%h sh=%0d norm=%h z=%b e=%b",
                       out_onehot, out_mask, out_shamt, out_norm, out_zero, out_err,
                       e.onehot, e.mask, e.shamt, e.norm, e.zero, e.err);
            end
            if (out_ready) begin
              if (tp_mode) begin
                checks++;
                if (cyc - e.cyc != 2) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles, required 2", cyc - e.cyc);
                end
              end
              void'(sb_q.pop_front());
            end
          end
        end else if (out_valid !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL out_valid_x: got %b, required 0 or 1", out_valid);
        end
        if (in_valid && in_ready) begin
          e = model(int'(in_pos), in_data);
          e.cyc = cyc;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] pos, input logic [19:0] data);
    bit ok;
    int tries;
    in_valid = 1'b1;
    in_pos   = pos;
    in_data  = data;
    tries    = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (tp_mode && tries == 0) begin
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL tp_stall: got in_ready=0, required 1");
        end
      end
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", tries);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_norm !== 20'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b rdy=%b norm=%h, required 0 1 00000",
               out_valid, in_ready, out_norm);
    end
    @(posedge clk);
    #1;

    for (int p = 0; p <= 20; p++) begin
      send(5'(p), (p == 0) ? 20'd0 : 20'(40'd1 << (p - 1)));
    end
    send(5'd13, 20'h01A5C);
    send(5'd21, 20'hABCDE);
    send(5'd31, 20'hFFFFF);
    idle(1);
    drain();

    tp_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(5'($urandom_range(0, 20)), 20'($urandom));
    end
    idle(1);
    drain();
    tp_mode = 1'b0;

    or_mode = 1;
    for (int i = 0; i < 100; i++) begin
      send(5'($urandom_range(0, 31)), 20'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    or_mode = 0;
    idle(1);
    drain();

    or_mode = 2;
    idle(2);
    send(5'd5, 20'h00013);
    send(5'd20, 20'h80001);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    or_mode = 0;
    idle(10);
    send(5'd13, 20'h01A5C);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_dec_20.md
# priority_dec_20

Inverse of the 20-bit leading-one priority encoder in the 16b_frac PE datapath. It accepts a leading-one position code and the 20-bit fraction word that produced it. It returns the one-hot position, the thermometer mask of bits below the leading one, the left-shift amount, and the fraction normalized so its leading one lands at bit 19. It is a 2-stage valid/ready pipeline that sits between the priority encoder and the PE rounding/packing stage.

## Interface
- WIDTH, 20: fraction width; position code range 0..WIDTH.
- POS_W, 5: position code width, $clog2(WIDTH+1).
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts input this cycle.
- in_pos  input  POS_W  position code: 0 = all-zero word; k in 1..20 = leading one at bit k-1.
- in_data  input  WIDTH  fraction word.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts output.
- out_onehot  output  WIDTH  bit k-1 set for code k; all zero for code 0.
- out_mask  output  WIDTH  bits [k-2:0] set, i.e. ones below the leading one; zero for codes 0 and 1.
- out_shamt  output  POS_W  WIDTH − k for k ≥ 1; 0 for code 0.
- out_norm  output  WIDTH  in_data << out_shamt, truncated to WIDTH bits.
- out_zero  output  1  code was 0.
- out_err  output  1  code > WIDTH (21..31).

## Operation
- Stage 1 (S1) registers in_data, and also registers the decoded onehot, mask, shamt, zero and err flags computed from in_pos.
- Stage 2 (S2) registers the barrel-shifted data together with the S1 side-band fields. The S2 registers drive the outputs directly.
- Error code (in_pos > 20): onehot = 0, mask = 0, shamt = 0, norm = 0, zero = 0, err = 1. The beat is passed through and never dropped.
- Code 0: norm = in_data, unshifted (the expected value is 0, but non-zero data is not checked). zero = 1.
- in_data is not checked against in_pos. norm is computed from shamt alone; any bits shifted out above bit 19 are discarded.
- Handshakes:
  - A transfer occurs on valid && ready at both ports.
  - Once out_valid is raised, it and all out_* fields must hold stable until out_ready.
  - in_valid/in_pos/in_data are sampled only when in_ready is high.
- Advance rules:
  - S2 loads when S2 is empty or out_ready is high.
  - S1 loads when S1 is empty or S1 is advancing into S2.
  - in_ready = !s1_valid || s2_load. This is a combinational path from out_ready.
- No skid buffer. A full pipeline with out_ready low holds both stages and drives in_ready low.

## Timing
- Reset: s1_valid = s2_valid = 0, so out_valid = 0 and in_ready = 1 from reset assertion. All data registers reset to 0, so out_* = 0.
- Latency: an accepted beat appears on the outputs exactly 2 cycles after acceptance when unstalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Simultaneous events:
  - Accept and emit in the same cycle on a full pipe: both stages shift and a new beat enters S1. No bubble, no loss.
  - Stall release: when out_ready rises with both stages full, S2 updates next edge from S1, and S1 accepts a new beat the same cycle if in_valid is high.
- Reset mid-operation: in-flight beats are discarded and nothing is emitted after rst_n deasserts until new input is accepted. A new beat may be accepted on the first edge after deassertion.
- Ordering: strictly in order; no beat is duplicated or reordered under any stall pattern.

## Structure
- Shared package pe_frac_pkg holds:
  - the WIDTH and POS_W localparams;
  - typedef frac_t (logic [WIDTH-1:0]) and pos_t (logic [POS_W-1:0]);
  - function pos2onehot and function pos2mask, reused by the encoder-side checkers.
- One sub-module, shl_barrel_20: combinational 5-level logarithmic left shifter (frac_t, pos_t → frac_t), instantiated between S1 and S2.
- The rest of the logic (the two valid-tracked register stages) is flat in priority_dec_20, about 200 lines.

## Test plan
- Reset/idle: assert rst_n low, release → out_valid = 0, in_ready = 1, out_norm = 0. Reset mid-stream with 2 beats in flight → nothing emitted after release.
- Decode sweep: pos 0..20 with data = 1 << (pos−1). Each beat yields:
  - out_norm = 0x80000;
  - out_shamt = 20 − pos;
  - onehot = data;
  - mask = data − 1.
  - pos = 0 yields norm = 0 and zero = 1.
- Example beat: pos = 13, data = 0x01A5C → shamt = 7, norm = 0xD2E00, onehot = 0x01000, mask = 0x00FFF.
- Error codes: pos = 21 and pos = 31 → err = 1 and all other fields 0. Beat count is preserved.
- Backpressure:
  - Stream 100 random beats with out_ready low 50% of the time.
  - Required: in-order delivery matching a reference model, with outputs stable during every stall.
  - Required: in_ready = 0 only while both stages are full and out_ready = 0.
- Full throughput: in_valid = out_ready = 1 for 32 beats → first out_valid 2 cycles after the first accept, then 32 consecutive beats with no bubbles.
